// File: rtl/sdp_ram_bytewise.sv
// Simple-dual-port RAM with byte enables, registered read port and a zeroing clear sweep.
// Define SDP_RAM_PARITY_EN to store one even-parity bit per byte and flag mismatches on read.
module sdp_ram_bytewise #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    rd,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic                    clr,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    rd_perr
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DepthExt = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    rd_valid_q, rd_valid_d;

  logic                    wr_en, rd_en, sweep_en, rd_in_range, same_addr;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  function automatic logic [NumBytes-1:0] byte_par(input logic [DATA_WIDTH-1:0] w);
    logic [NumBytes-1:0] p;
    p = '0;
    for (int k = 0; k < NumBytes; k++) p[k] = ^w[8*k +: 8];
    return p;
  endfunction

  always_comb begin
    sweep_en    = (state_q == StClear);
    wr_en       = (state_q == StReady) && wr && !clr && ({1'b0, wr_addr} < DepthExt);
    rd_en       = (state_q == StReady) && rd && !clr;
    rd_in_range = ({1'b0, rd_addr} < DepthExt);
    same_addr   = wr_en && (rd_addr == wr_addr);

    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StClear: begin
        if (ptr_q == LastAddr) state_d = StReady;
        else                   ptr_d   = ptr_q + 1'b1;
      end
      StReady: begin
        if (clr) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
      default: state_d = StClear;
    endcase
    busy_d = (state_d == StClear);

    rd_word = rd_in_range ? mem[rd_addr] : '0;
    // Write-first: merge the enabled bytes of the concurrent write into the read result.
    if (RDW_MODE == 1 && same_addr) begin
      for (int k = 0; k < NumBytes; k++) begin
        if (wr_be[k]) rd_word[8*k +: 8] = din[8*k +: 8];
      end
    end
    dout_d     = rd_en ? rd_word : dout_q;
    rd_valid_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (sweep_en) begin
      mem[ptr_q] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NumBytes; k++) begin
        if (wr_be[k]) mem[wr_addr][8*k +: 8] <= din[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StClear;
      ptr_q      <= '0;
      busy_q     <= 1'b1;
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef SDP_RAM_PARITY_EN
  logic [NumBytes-1:0] par_mem [DEPTH];
  logic [NumBytes-1:0] rd_par;
  logic                rd_perr_q, rd_perr_d;

  always_comb begin
    rd_par = rd_in_range ? par_mem[rd_addr] : '0;
    if (RDW_MODE == 1 && same_addr) begin
      for (int k = 0; k < NumBytes; k++) begin
        if (wr_be[k]) rd_par[k] = ^din[8*k +: 8];
      end
    end
    rd_perr_d = rd_en && |(rd_par ^ byte_par(rd_word));
  end

  always_ff @(posedge clk) begin
    if (sweep_en) begin
      par_mem[ptr_q] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NumBytes; k++) begin
        if (wr_be[k]) par_mem[wr_addr][k] <= ^din[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_perr_q <= 1'b0;
    else        rd_perr_q <= rd_perr_d;
  end

  assign rd_perr = rd_perr_q;
`else
  assign rd_perr = 1'b0;
`endif

  assign dout     = dout_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;

endmodule
